scr1_ahb_arb2: RTL and testbench

Two-master AHB-Lite arbiter that shares one AHB master port between the instruction-memory bridge (master 0) and the data-memory bridge (master 1), e.g. for a single-port system bus. Each bridge may issue a NONSEQ address phase without waiting for HREADY. The arbiter therefore captures every accepted address phase in a per-master pending register. It then replays that phase on the shared bus when granted, and routes the data phase back to the owning master.

---
 rtl/scr1_ahb_arb2.sv | 165 ++++++++++++++++
 tb/tb_scr1_ahb_arb2.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_ahb_arb2.sv
// Two-master AHB-Lite arbiter: each master's accepted address phase is parked in a
// pending register, replayed on the shared bus when granted, and its data phase routed back.
module scr1_ahb_arb2 #(
    parameter int SCR1_ARB_RR    = 0,
    parameter int SCR1_AHB_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [SCR1_AHB_WIDTH-1:0] m0_haddr,
    input  logic [1:0]                m0_htrans,
    input  logic                      m0_hwrite,
    input  logic [2:0]                m0_hsize,
    input  logic [2:0]                m0_hburst,
    input  logic [3:0]                m0_hprot,
    input  logic [SCR1_AHB_WIDTH-1:0] m0_hwdata,
    output logic                      m0_hready,
    output logic [SCR1_AHB_WIDTH-1:0] m0_hrdata,
    output logic                      m0_hresp,

    input  logic [SCR1_AHB_WIDTH-1:0] m1_haddr,
    input  logic [1:0]                m1_htrans,
    input  logic                      m1_hwrite,
    input  logic [2:0]                m1_hsize,
    input  logic [2:0]                m1_hburst,
    input  logic [3:0]                m1_hprot,
    input  logic [SCR1_AHB_WIDTH-1:0] m1_hwdata,
    output logic                      m1_hready,
    output logic [SCR1_AHB_WIDTH-1:0] m1_hrdata,
    output logic                      m1_hresp,

    output logic [SCR1_AHB_WIDTH-1:0] s_haddr,
    output logic [1:0]                s_htrans,
    output logic                      s_hwrite,
    output logic [2:0]                s_hsize,
    output logic [2:0]                s_hburst,
    output logic [3:0]                s_hprot,
    output logic                      s_hmastlock,
    output logic [SCR1_AHB_WIDTH-1:0] s_hwdata,
    input  logic                      s_hready,
    input  logic [SCR1_AHB_WIDTH-1:0] s_hrdata,
    input  logic                      s_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic       HRESP_OKAY    = 1'b0;

    typedef struct packed {
        logic [SCR1_AHB_WIDTH-1:0] addr;
        logic                      write;
        logic [2:0]                size;
        logic [2:0]                burst;
        logic [3:0]                prot;
    } ahb_ctrl_t;

    logic [1:0] pend_vld;
    ahb_ctrl_t  pend_ctrl [2];
    ahb_ctrl_t  req_ctrl  [2];
    logic [1:0] cap;
    logic [1:0] outstanding;

    logic       dph_vld;
    logic       dph_own;
    logic       last_own;

    logic       slot_free;
    logic       sel;
    logic       aph_vld;
    logic       aph_own;

    assign req_ctrl[0] = '{m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hprot};
    assign req_ctrl[1] = '{m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hprot};

    assign cap[0] = (m0_htrans == HTRANS_NONSEQ) && m0_hready;
    assign cap[1] = (m1_htrans == HTRANS_NONSEQ) && m1_hready;

    // An ERROR completion is deliberately not a free slot, so the bus idles for that cycle.
    assign slot_free = !dph_vld || (s_hready && (s_hresp == HRESP_OKAY));

    // With nothing pending, sel falls back to the last owner so s_haddr stays stable.
    always_comb begin
        sel = last_own;
        if (pend_vld[0] && pend_vld[1]) begin
            sel = (SCR1_ARB_RR != 0) ? ~last_own : 1'b1;
        end else if (pend_vld[1]) begin
            sel = 1'b1;
        end else if (pend_vld[0]) begin
            sel = 1'b0;
        end
    end

    assign aph_vld = slot_free && (pend_vld != 2'b00);
    assign aph_own = sel;

    assign outstanding[0] = pend_vld[0] || (aph_vld && !aph_own) || (dph_vld && !dph_own);
    assign outstanding[1] = pend_vld[1] || (aph_vld &&  aph_own) || (dph_vld &&  dph_own);

    always_comb begin
        m0_hready = !outstanding[0];
        m0_hresp  = HRESP_OKAY;
        m1_hready = !outstanding[1];
        m1_hresp  = HRESP_OKAY;
        if (dph_vld && !dph_own) begin
            m0_hready = s_hready;
            m0_hresp  = s_hresp;
        end
        if (dph_vld && dph_own) begin
            m1_hready = s_hready;
            m1_hresp  = s_hresp;
        end
    end

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    assign s_htrans    = aph_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_haddr     = pend_ctrl[sel].addr;
    assign s_hwrite    = pend_ctrl[sel].write;
    assign s_hsize     = pend_ctrl[sel].size;
    assign s_hburst    = pend_ctrl[sel].burst;
    assign s_hprot     = pend_ctrl[sel].prot;
    assign s_hmastlock = 1'b0;
    assign s_hwdata    = !dph_vld ? '0 : (dph_own ? m1_hwdata : m0_hwdata);

    // Capture never coincides with issue for the same master: capture needs that master idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= '0;
            for (int i = 0; i < 2; i++) begin
                pend_ctrl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cap[i]) begin
                    pend_vld[i]  <= 1'b1;
                    pend_ctrl[i] <= req_ctrl[i];
                end else if (aph_vld && (aph_own == 1'(i))) begin
                    pend_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_vld  <= 1'b0;
            dph_own  <= 1'b0;
            last_own <= 1'b1;
        end else if (aph_vld) begin
            dph_vld  <= 1'b1;
            dph_own  <= aph_own;
            last_own <= aph_own;
        end else if (dph_vld && s_hready) begin
            dph_vld <= 1'b0;
        end
    end

    // Masters are single-transfer bridges: no SEQ/BUSY, and no capture on top of a pending one.
    assert property (@(posedge clk) disable iff (!rst_n) !(m0_htrans inside {2'b01, 2'b11}));
    assert property (@(posedge clk) disable iff (!rst_n) !(m1_htrans inside {2'b01, 2'b11}));
    assert property (@(posedge clk) disable iff (!rst_n) !(cap[0] && pend_vld[0]));
    assert property (@(posedge clk) disable iff (!rst_n) !(cap[1] && pend_vld[1]));

endmodule

// File: tb/tb_scr1_ahb_arb2.sv
// Directed bench for scr1_ahb_arb2: fixed-priority and round-robin instances share stimulus,
// expected bus address phases are queued at request time and popped when the bus issues.
module tb_scr1_ahb_arb2;
    localparam int         W      = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic [W-1:0] m0_haddr = '0, m1_haddr = '0;
    logic [1:0]   m0_htrans = IDLE, m1_htrans = IDLE;
    logic         m0_hwrite = 1'b0, m1_hwrite = 1'b0;
    logic [2:0]   m0_hsize = 3'd2, m1_hsize = 3'd2;
    logic [2:0]   m0_hburst = 3'd0, m1_hburst = 3'd0;
    logic [3:0]   m0_hprot = 4'd3, m1_hprot = 4'd3;
    logic [W-1:0] m0_hwdata = '0, m1_hwdata = '0;
    logic         s_hready = 1'b1;
    logic [W-1:0] s_hrdata = '0;
    logic         s_hresp = 1'b0;

    logic         m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [W-1:0] m0_hrdata, m1_hrdata;
    logic [W-1:0] s_haddr, s_hwdata;
    logic [1:0]   s_htrans;
    logic         s_hwrite, s_hmastlock;
    logic [2:0]   s_hsize, s_hburst;
    logic [3:0]   s_hprot;

    logic         rr_m0_hready, rr_m1_hready, rr_m0_hresp, rr_m1_hresp;
    logic [W-1:0] rr_m0_hrdata, rr_m1_hrdata;
    logic [W-1:0] rr_s_haddr, rr_s_hwdata;
    logic [1:0]   rr_s_htrans;
    logic         rr_s_hwrite, rr_s_hmastlock;
    logic [2:0]   rr_s_hsize, rr_s_hburst;
    logic [3:0]   rr_s_hprot;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_addr_q[$];

    scr1_ahb_arb2 #(.SCR1_ARB_RR(0), .SCR1_AHB_WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata),
        .m0_hready(m0_hready), .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata),
        .m1_hready(m1_hready), .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
        .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    scr1_ahb_arb2 #(.SCR1_ARB_RR(1), .SCR1_AHB_WIDTH(W)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hwdata(m0_hwdata),
        .m0_hready(rr_m0_hready), .m0_hrdata(rr_m0_hrdata), .m0_hresp(rr_m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hwdata(m1_hwdata),
        .m1_hready(rr_m1_hready), .m1_hrdata(rr_m1_hrdata), .m1_hresp(rr_m1_hresp),
        .s_haddr(rr_s_haddr), .s_htrans(rr_s_htrans), .s_hwrite(rr_s_hwrite), .s_hsize(rr_s_hsize),
        .s_hburst(rr_s_hburst), .s_hprot(rr_s_hprot), .s_hmastlock(rr_s_hmastlock),
        .s_hwdata(rr_s_hwdata),
        .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard only when an address phase is expected on the bus this cycle.
    task automatic checkIssue(input string tag, input logic [1:0] trans, input logic [W-1:0] addr,
                              input bit issue);
        logic [W-1:0] e;
        if (issue) begin
            checkOutput({tag, "_htrans"}, W'(trans), W'(NONSEQ));
            checkOutput({tag, "_sb_has_entry"}, W'(exp_addr_q.size() != 0), W'(1));
            if (exp_addr_q.size() != 0) begin
                e = exp_addr_q.pop_front();
                checkOutput({tag, "_haddr"}, addr, e);
            end
        end else begin
            checkOutput({tag, "_htrans_idle"}, W'(trans), W'(IDLE));
        end
    endtask

    task automatic applyStimulus(input int m, input logic [1:0] trans, input logic [W-1:0] addr,
                                 input logic wr);
        if (m == 0) begin
            m0_htrans = trans;
            m0_haddr  = addr;
            m0_hwrite = wr;
        end else begin
            m1_htrans = trans;
            m1_haddr  = addr;
            m1_hwrite = wr;
        end
    endtask

    initial begin
        // Reset state
        #3;
        checkIssue("rst", s_htrans, s_haddr, 0);
        checkOutput("rst_haddr", s_haddr, '0);
        checkOutput("rst_m0_hready", W'(m0_hready), W'(1));
        checkOutput("rst_m1_hready", W'(m1_hready), W'(1));
        checkOutput("rst_m0_hresp", W'(m0_hresp), W'(0));
        checkOutput("rst_hmastlock", W'(s_hmastlock), W'(0));
        tick();
        rst_n = 1'b1;

        // Master 0 alone
        tick();
        applyStimulus(0, NONSEQ, 32'h100, 1'b0);
        exp_addr_q.push_back(32'h100);
        #2;
        checkIssue("m0_t0", s_htrans, s_haddr, 0);
        checkOutput("m0_t0_hready", W'(m0_hready), W'(1));
        tick();
        applyStimulus(0, IDLE, 32'h100, 1'b0);
        #2;
        checkIssue("m0_t1", s_htrans, s_haddr, 1);
        checkOutput("m0_t1_hready", W'(m0_hready), W'(0));
        checkOutput("m0_t1_hsize", W'(s_hsize), W'(2));
        tick();
        s_hrdata = 32'hDEADBEEF;
        s_hready = 1'b1;
        #2;
        checkOutput("m0_t2_hready", W'(m0_hready), W'(1));
        checkOutput("m0_t2_hrdata", m0_hrdata, 32'hDEADBEEF);
        checkOutput("m0_t2_m1_hready", W'(m1_hready), W'(1));
        checkIssue("m0_t2", s_htrans, s_haddr, 0);

        // Fixed priority: master 1 wins
        tick();
        applyStimulus(0, NONSEQ, 32'h200, 1'b0);
        applyStimulus(1, NONSEQ, 32'h300, 1'b0);
        exp_addr_q.push_back(32'h300);
        exp_addr_q.push_back(32'h200);
        tick();
        applyStimulus(0, IDLE, 32'h200, 1'b0);
        applyStimulus(1, IDLE, 32'h300, 1'b0);
        #2;
        checkIssue("fp_t1", s_htrans, s_haddr, 1);
        checkOutput("fp_t1_m0_hready", W'(m0_hready), W'(0));
        tick();
        #2;
        checkIssue("fp_t2", s_htrans, s_haddr, 1);
        checkOutput("fp_t2_m1_hready", W'(m1_hready), W'(1));
        checkOutput("fp_t2_m0_hready", W'(m0_hready), W'(0));
        tick();
        #2;
        checkOutput("fp_t3_m0_hready", W'(m0_hready), W'(1));
        checkIssue("fp_t3", s_htrans, s_haddr, 0);

        // Wait states on an m1 write with m0 queued behind it
        tick();
        applyStimulus(1, NONSEQ, 32'h400, 1'b1);
        exp_addr_q.push_back(32'h400);
        tick();
        applyStimulus(1, IDLE, 32'h400, 1'b0);
        m1_hwdata = 32'h55AA;
        applyStimulus(0, NONSEQ, 32'h500, 1'b0);
        exp_addr_q.push_back(32'h500);
        #2;
        checkIssue("ws_t1", s_htrans, s_haddr, 1);
        checkOutput("ws_t1_hwrite", W'(s_hwrite), W'(1));
        checkOutput("ws_t1_m0_hready", W'(m0_hready), W'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(0, IDLE, 32'h500, 1'b0);
            s_hready = 1'b0;
            #2;
            checkOutput($sformatf("ws_wait%0d_hwdata", k), s_hwdata, 32'h55AA);
            checkOutput($sformatf("ws_wait%0d_m1_hready", k), W'(m1_hready), W'(0));
            checkOutput($sformatf("ws_wait%0d_haddr", k), s_haddr, 32'h500);
            checkIssue($sformatf("ws_wait%0d", k), s_htrans, s_haddr, 0);
        end
        tick();
        s_hready = 1'b1;
        #2;
        checkOutput("ws_done_hwdata", s_hwdata, 32'h55AA);
        checkOutput("ws_done_m1_hready", W'(m1_hready), W'(1));
        checkIssue("ws_done", s_htrans, s_haddr, 1);
        checkOutput("ws_done_hwrite", W'(s_hwrite), W'(0));
        tick();
        m1_hwdata = '0;
        #2;
        checkOutput("ws_m0_hready", W'(m0_hready), W'(1));
        checkOutput("ws_m0_hwdata", s_hwdata, '0);

        // ERROR to m0 while m1 is pending
        tick();
        applyStimulus(0, NONSEQ, 32'h600, 1'b0);
        exp_addr_q.push_back(32'h600);
        tick();
        applyStimulus(0, IDLE, 32'h600, 1'b0);
        applyStimulus(1, NONSEQ, 32'h700, 1'b0);
        exp_addr_q.push_back(32'h700);
        #2;
        checkIssue("err_t1", s_htrans, s_haddr, 1);
        tick();
        applyStimulus(1, IDLE, 32'h700, 1'b0);
        s_hready = 1'b0;
        s_hresp  = 1'b1;
        #2;
        checkIssue("err_t2", s_htrans, s_haddr, 0);
        checkOutput("err_t2_m0_hresp", W'(m0_hresp), W'(1));
        checkOutput("err_t2_m0_hready", W'(m0_hready), W'(0));
        tick();
        s_hready = 1'b1;
        #2;
        checkOutput("err_t3_m0_hresp", W'(m0_hresp), W'(1));
        checkOutput("err_t3_m0_hready", W'(m0_hready), W'(1));
        checkOutput("err_t3_m1_hresp", W'(m1_hresp), W'(0));
        checkOutput("err_t3_m1_hready", W'(m1_hready), W'(0));
        checkIssue("err_t3", s_htrans, s_haddr, 0);
        tick();
        s_hresp = 1'b0;
        #2;
        checkIssue("err_t4", s_htrans, s_haddr, 1);
        tick();
        #2;
        checkOutput("err_t5_m1_hready", W'(m1_hready), W'(1));

        // Round-robin instance from a fresh reset
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tick();
            applyStimulus(0, NONSEQ, 32'h200, 1'b0);
            applyStimulus(1, NONSEQ, 32'h300, 1'b0);
            exp_addr_q.push_back(32'h200);
            exp_addr_q.push_back(32'h300);
            tick();
            applyStimulus(0, IDLE, 32'h200, 1'b0);
            applyStimulus(1, IDLE, 32'h300, 1'b0);
            #2;
            checkIssue($sformatf("rr%0d_first", r), rr_s_htrans, rr_s_haddr, 1);
            tick();
            #2;
            checkIssue($sformatf("rr%0d_second", r), rr_s_htrans, rr_s_haddr, 1);
            checkOutput($sformatf("rr%0d_m0_hready", r), W'(rr_m0_hready), W'(1));
            tick();
            #2;
            checkOutput($sformatf("rr%0d_m1_hready", r), W'(rr_m1_hready), W'(1));
            checkIssue($sformatf("rr%0d_idle", r), rr_s_htrans, rr_s_haddr, 0);
        end

        // Reset while m0 is in its data phase and m1 is pending
        tick();
        applyStimulus(0, NONSEQ, 32'h800, 1'b0);
        exp_addr_q.push_back(32'h800);
        tick();
        applyStimulus(0, IDLE, 32'h800, 1'b0);
        applyStimulus(1, NONSEQ, 32'h900, 1'b0);
        #2;
        checkIssue("mr_t1", s_htrans, s_haddr, 1);
        tick();
        applyStimulus(1, IDLE, 32'h900, 1'b0);
        s_hready = 1'b0;
        #2;
        checkOutput("mr_pre_m0_hready", W'(m0_hready), W'(0));
        rst_n = 1'b0;
        #1;
        checkIssue("mr_rst", s_htrans, s_haddr, 0);
        checkOutput("mr_rst_m0_hready", W'(m0_hready), W'(1));
        checkOutput("mr_rst_m1_hready", W'(m1_hready), W'(1));
        tick();
        tick();
        rst_n    = 1'b1;
        s_hready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            checkIssue($sformatf("mr_after%0d", k), s_htrans, s_haddr, 0);
            checkIssue($sformatf("mr_after%0d_rr", k), rr_s_htrans, rr_s_haddr, 0);
        end
        checkOutput("sb_empty", W'(exp_addr_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
